// File: rtl/atan_poly_seq.sv
// -----------------------------------------------------------------------------
// atan_poly_seq
//   Evaluates atan(x) ~= x*(K1 - B*x^2) on unsigned Q0.8 inputs, one sample
//   per input handshake. x^2 and x*u come from a local 8x8 multiplier. The
//   B*x^2 product comes from an external pipelined constant-B multiplier
//   whose latency is MUL_LAT cycles. The result is Q0.8 radians.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   in_valid_i   x_i valid
//   in_ready_o   block can accept x_i (combinational, high in IDLE)
//   x_i          input ratio, unsigned Q0.8
//   mul_b_a_o    operand to external multiplier input A (x^2 in MULB, else 0)
//   mul_b_p_i    external multiplier product P = A*B, B in Q0.8
//   out_valid_o  atan_o valid
//   out_ready_i  downstream accepts atan_o
//   atan_o       result, unsigned Q0.8 radians
//   busy_o       high in any state other than IDLE
// -----------------------------------------------------------------------------
module atan_poly_seq #(
  parameter int unsigned MUL_LAT = 3,       // external multiplier latency, 1..15
  parameter logic [7:0]  K1      = 8'd249   // Q0.8 linear coefficient
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [7:0]  x_i,
  output logic [7:0]  mul_b_a_o,
  input  logic [15:0] mul_b_p_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [7:0]  atan_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    MULB = 3'd2,
    SUB  = 3'd3,
    FIN  = 3'd4,
    OUT  = 3'd5
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MUL_LAT);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  xr;
  logic [7:0]  x2;
  logic [7:0]  t;
  logic [7:0]  u;
  logic [3:0]  cnt;
  logic [15:0] sq_prod;
  logic [15:0] fin_prod;

  // Both local products are full 16-bit unsigned; only the upper byte is kept.
  assign sq_prod  = {8'd0, xr} * {8'd0, xr};
  assign fin_prod = {8'd0, xr} * {8'd0, u};

  // Low product bytes are discarded by design (truncation to [15:8]).
  logic unused_lsbs;
  assign unused_lsbs = ^{mul_b_p_i[7:0], sq_prod[7:0], fin_prod[7:0]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps every path assigned, so no
  // latch is inferred when a case branch leaves the state unchanged.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid_i)          state_nxt = SQ;
      SQ:                            state_nxt = MULB;
      MULB: if (cnt == CNT_LAST)     state_nxt = SUB;
      SUB:                           state_nxt = FIN;
      FIN:                           state_nxt = OUT;
      OUT:  if (out_ready_i)         state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Combinational outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_o = (state == IDLE);
    busy_o     = (state != IDLE);
    // Operand is only driven while waiting on the product, so the external
    // pipeline sees a clean, stable A for the whole MULB dwell.
    mul_b_a_o  = (state == MULB) ? x2 : 8'd0;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr          <= '0;
      x2          <= '0;
      t           <= '0;
      u           <= '0;
      cnt         <= '0;
      atan_o      <= '0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) xr <= x_i;
        SQ: begin
          x2  <= sq_prod[15:8];
          cnt <= '0;
        end
        MULB: begin
          cnt <= cnt + 4'd1;
          // A was first presented on MULB entry, so the matching product is
          // on the bus exactly MUL_LAT cycles later.
          if (cnt == CNT_LAST) t <= mul_b_p_i[15:8];
        end
        SUB: u <= (K1 >= t) ? (K1 - t) : 8'd0;   // saturate, never wrap
        FIN: begin
          atan_o      <= fin_prod[15:8];
          out_valid_o <= 1'b1;
        end
        OUT: if (out_ready_i) out_valid_o <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atan_poly_seq.sv
// -----------------------------------------------------------------------------
// tb_atan_poly_seq
//   Self-checking bench for atan_poly_seq. Two instances share stimulus: one
//   with K1=249 and one with K1=10 (saturation build). Each has its own model
//   of the external multiplier, P = A*49 delayed by MUL_LAT registers.
//   Expected results are pushed to queues on input accept and popped when the
//   DUT transfers a result.
// -----------------------------------------------------------------------------
module tb_atan_poly_seq;

  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned B_CONST = 49;
  localparam int unsigned LAT     = MUL_LAT + 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i;
  logic [7:0]  x_i;
  logic        out_ready_i;

  logic        in_ready_o,  in_ready_s;
  logic [7:0]  mul_a,       mul_a_s;
  logic [15:0] mul_p,       mul_p_s;
  logic        out_valid_o, out_valid_s;
  logic [7:0]  atan_o,      atan_s;
  logic        busy_o,      busy_s;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [7:0] q_main[$];
  logic [7:0] q_sat[$];

  int         mul_cnt = 0;
  logic [7:0] mul_exp = 8'd0;
  bit         mul_bad = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  atan_poly_seq #(.MUL_LAT(MUL_LAT), .K1(8'd249)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .x_i(x_i), .mul_b_a_o(mul_a), .mul_b_p_i(mul_p), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .atan_o(atan_o), .busy_o(busy_o)
  );

  atan_poly_seq #(.MUL_LAT(MUL_LAT), .K1(8'd10)) dut_sat (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_s),
    .x_i(x_i), .mul_b_a_o(mul_a_s), .mul_b_p_i(mul_p_s), .out_valid_o(out_valid_s),
    .out_ready_i(out_ready_i), .atan_o(atan_s), .busy_o(busy_s)
  );

  // External constant-B multiplier models (no reset, like a real pipeline).
  logic [15:0] pipe_m[MUL_LAT];
  logic [15:0] pipe_s[MUL_LAT];
  always @(posedge clk) begin
    pipe_m[0] <= {8'd0, mul_a}   * 16'(B_CONST);
    pipe_s[0] <= {8'd0, mul_a_s} * 16'(B_CONST);
    for (int i = 1; i < MUL_LAT; i++) begin
      pipe_m[i] <= pipe_m[i-1];
      pipe_s[i] <= pipe_s[i-1];
    end
  end
  assign mul_p   = pipe_m[MUL_LAT-1];
  assign mul_p_s = pipe_s[MUL_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference formula for random vectors.
  function automatic logic [7:0] ref_atan(input logic [7:0] x, input logic [7:0] k1);
    logic [15:0] p;
    logic [7:0]  x2, t, u;
    p  = {8'd0, x} * {8'd0, x};        x2 = p[15:8];
    p  = {8'd0, x2} * 16'(B_CONST);    t  = p[15:8];
    u  = (k1 >= t) ? k1 - t : 8'd0;
    p  = {8'd0, x} * {8'd0, u};
    return p[15:8];
  endfunction

  // Output scoreboard: sample between edges, pop on each transfer.
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      if (q_main.size() == 0) check("unexpected_out_main", 32'(atan_o), 32'hDEAD);
      else check("atan_main", 32'(atan_o), 32'(q_main.pop_front()));
    end
    if (out_valid_s && out_ready_i) begin
      if (q_sat.size() == 0) check("unexpected_out_sat", 32'(atan_s), 32'hDEAD);
      else check("atan_sat", 32'(atan_s), 32'(q_sat.pop_front()));
    end
    if (mul_a != 8'd0) begin
      mul_cnt++;
      if (mul_a != mul_exp) mul_bad = 1'b1;
    end
  end

  // Drive one sample; waits (bounded) for in_ready_o. Accept cycle is recorded.
  task automatic send(input logic [7:0] x, input logic [7:0] e_main,
                      input logic [7:0] e_sat, input bit push);
    int n = 0;
    while (!in_ready_o && n < 64) begin @(posedge clk); #1; n++; end
    if (!in_ready_o) begin check("in_ready_timeout", 0, 1); return; end
    in_valid_i = 1'b1;
    x_i        = x;
    acc_cyc    = cyc;
    if (push) begin
      q_main.push_back(e_main);
      q_sat.push_back(e_sat);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Wait (bounded) for out_valid_o; returns the cycle index it was first seen.
  task automatic wait_out(output int seen);
    int n = 0;
    while (!out_valid_o && n < 64) begin @(posedge clk); #1; n++; end
    seen = cyc;
    if (!out_valid_o) check("out_valid_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] x2;
    logic [7:0] e_main;
    logic [7:0] e_sat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int seen;
    vecs[0] = '{8'h00, 8'd0,   8'h00, 8'h00};
    vecs[1] = '{8'hFF, 8'd254, 8'hC8, 8'h00};
    vecs[2] = '{8'h80, 8'd64,  8'h76, 8'h00};
    vecs[3] = '{8'h40, 8'd16,  8'h3D, 8'h01};
    vecs[4] = '{8'hC0, 8'd144, 8'hA6, 8'h00};
    vecs[5] = '{8'h10, 8'd1,   8'h0F, 8'h00};
    vecs[6] = '{8'h60, 8'd36,  8'h5B, 8'h01};
    vecs[7] = '{8'hE0, 8'd196, 8'hB9, 8'h00};

    rst = 1'b1; in_valid_i = 1'b1; x_i = 8'hFF; out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, out_valid_o, atan_o, mul_a, busy_o}, 32'd0);
    check("reset_sat_outputs", {24'd0, out_valid_s, atan_s, mul_a_s, busy_s}, 32'd0);
    in_valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", {30'd0, in_ready_o, busy_o}, 32'b10);

    // Table-driven vectors, no backpressure.
    for (int i = 0; i < 8; i++) begin
      mul_cnt = 0; mul_bad = 1'b0; mul_exp = vecs[i].x2;
      send(vecs[i].x, vecs[i].e_main, vecs[i].e_sat, 1'b1);
      wait_out(seen);
      // Accept in cycle 0 -> valid first high in cycle MUL_LAT+5.
      check($sformatf("latency_x%0h", vecs[i].x), 32'(seen - acc_cyc), 32'(LAT));
      @(posedge clk); #1;
      check($sformatf("handshake_done_x%0h", vecs[i].x), {30'd0, out_valid_o, in_ready_o}, 32'b01);
      check($sformatf("mulb_dwell_x%0h", vecs[i].x), 32'(mul_cnt),
            (vecs[i].x2 != 8'd0) ? 32'(MUL_LAT + 1) : 32'd0);
      check($sformatf("mulb_operand_x%0h", vecs[i].x), 32'(mul_bad), 32'd0);
    end

    // A few random samples against the reference formula.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] xr;
      xr = 8'($urandom_range(0, 255));
      mul_exp = 8'd0; mul_bad = 1'b0; mul_cnt = 0;
      send(xr, ref_atan(xr, 8'd249), ref_atan(xr, 8'd10), 1'b1);
      wait_out(seen);
      @(posedge clk); #1;
    end

    // Backpressure: hold OUT for 10 cycles, pulse in_valid_i meanwhile.
    out_ready_i = 1'b0;
    send(8'h80, 8'h76, 8'h00, 1'b1);
    wait_out(seen);
    check("bp_latency", 32'(seen - acc_cyc), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      x_i        = 8'hFF;
      check($sformatf("bp_hold_%0d", i), {22'd0, out_valid_o, in_ready_o, atan_o}, {22'd0, 2'b10, 8'h76});
      @(posedge clk); #1;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {30'd0, out_valid_o, in_ready_o}, 32'b01);
    check("bp_atan_kept", 32'(atan_o), 32'h76);
    repeat (3) @(posedge clk); #1;
    check("bp_no_extra_accept", 32'(busy_o), 32'd0);

    // Reset during MULB: no result may escape, then a clean transaction.
    begin
      int n = 0;
      send(8'hFF, 8'h00, 8'h00, 1'b0);
      while (mul_a == 8'd0 && n < 16) begin @(posedge clk); #1; n++; end
      check("reached_mulb", 32'(mul_a), 32'd254);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("midrst_outputs", {24'd0, out_valid_o, atan_o, mul_a, busy_o}, 32'd0);
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk); #1;
      check("midrst_quiet", {30'd0, out_valid_o, out_valid_s}, 32'd0);
    end
    mul_cnt = 0; mul_bad = 1'b0; mul_exp = 8'd64;
    send(8'h80, 8'h76, 8'h00, 1'b1);
    wait_out(seen);
    check("postrst_latency", 32'(seen - acc_cyc), 32'(LAT));
    @(posedge clk); #1;
    check("postrst_mulb_dwell", 32'(mul_cnt), 32'(MUL_LAT + 1));

    repeat (4) @(posedge clk); #1;
    check("scoreboard_drained", 32'(q_main.size() + q_sat.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/atan_poly_seq.md
Name: atan_poly_seq

Overview:
- Sequencer that drives the constant-B multiplier (operand out, 16-bit product back) and evaluates a fixed-point arctan approximation.
- Function: atan(x) ~= x*(K1 - B*x^2).
  - x is unsigned Q0.8 in [0,1); the result is Q0.8 radians.
- Accepts one sample per valid/ready handshake.
- Uses an internal 8x8 multiplier for x^2 and x*u.
- Offloads the B*x^2 product to the external pipelined constant-B multiplier (mul_para_B, constant B, latency MUL_LAT).
- Presents the result on a valid/ready output.

Parameters:
- MUL_LAT, 3: pipeline latency of the external constant-B multiplier in clk cycles (1..15).
- K1, 8'd249: Q0.8 linear coefficient (~0.9727).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  x_i valid
- in_ready_o  out  1  block can accept x_i
- x_i  in  8  input ratio, unsigned Q0.8
- mul_b_a_o  out  8  operand to the external multiplier input A
- mul_b_p_i  in  16  external multiplier product P = A*B, B in Q0.8
- out_valid_o  out  1  atan_o valid
- out_ready_i  in  1  downstream accepts atan_o
- atan_o  out  8  result, unsigned Q0.8 radians
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous, active-high. While rst=1:
  - state=IDLE; all datapath registers 0.
  - out_valid_o=0, atan_o=0, mul_b_a_o=0, busy_o=0.
  - Inputs are ignored.
- in_ready_o is combinational: (state==IDLE). It may read 1 while rst=1, but no capture occurs during reset.
- FSM states: IDLE, SQ, MULB, SUB, FIN, OUT.
- IDLE:
  - On in_valid_i & in_ready_o, register x_i to xr; go to SQ.
  - Otherwise hold.
- SQ:
  - x2 <= (xr*xr)[15:8] (truncate).
  - cnt <= 0; go to MULB.
- MULB:
  - mul_b_a_o = x2, held stable for the whole state; mul_b_a_o = 0 in every other state.
  - cnt increments each cycle.
  - When cnt==MUL_LAT: capture t <= mul_b_p_i[15:8], go to SUB.
  - Dwell time is MUL_LAT+1 cycles, matching a product that appears MUL_LAT cycles after A is presented.
- SUB:
  - u <= (K1 >= t) ? K1 - t : 0. Saturate at 0, no wrap.
  - Go to FIN.
- FIN:
  - atan_o <= (xr*u)[15:8] (truncate).
  - out_valid_o <= 1; go to OUT.
- OUT:
  - atan_o and out_valid_o are held stable until out_ready_i=1.
  - On handshake: out_valid_o <= 0, go to IDLE.
  - atan_o keeps its last value until overwritten by the next FIN.
- Latency: if the input handshake occurs in cycle 0, out_valid_o is first high in cycle MUL_LAT+5 (8 for the default).
- Throughput: without backpressure, the next accept occurs in cycle MUL_LAT+6 or later. There is no IDLE bypass, and OUT never accepts new input.
- Backpressure: out_ready_i=0 holds OUT indefinitely; in_ready_o stays 0 throughout.
- Simultaneous events: in_valid_i asserted outside IDLE is ignored; the source must hold it until in_ready_o rises.
- Reset mid-operation (any state, including MULB): immediately return to IDLE with the reset values above. A partial result is never emitted, and the following transaction is unaffected by stale multiplier pipeline contents.
- Boundary cases:
  - x=0 gives atan_o=0.
  - K1 < t saturates u to 0, giving atan_o=0.
  - All intermediate products are unsigned and 16-bit, truncated to bits [15:8].

Test Plan (bench models the external multiplier as P = A*49, delayed MUL_LAT=3 registers; K1=249):
1. Reset, then x_i=0x00 with out_ready_i=1 -> out_valid_o rises exactly 8 cycles after accept; atan_o=0x00.
2. x_i=0xFF -> x2=254, t=48, u=201; atan_o=0xC8 (200).
3. x_i=0x80 -> x2=64, t=12, u=237; atan_o=0x76 (118). mul_b_a_o=0x40 held for exactly 4 cycles, 0 otherwise.
4. Backpressure: x_i=0x80 with out_ready_i=0 for 10 cycles after out_valid_o rises -> atan_o stable at 0x76; in_ready_o=0 and in_valid_i pulses ignored. Raise out_ready_i -> single transfer, then in_ready_o=1 next cycle.
5. Saturation: build with K1=10, x_i=0xFF -> t=48 > 10 -> u=0 -> atan_o=0x00, no wrap.
6. Assert rst during MULB of x_i=0xFF -> all outputs 0, no out_valid_o pulse. Then x_i=0x80 -> atan_o=0x76 after 8 cycles.
